// File: rtl/nios_pio_input_irq_pkg.sv
// Shared definitions for the input PIO with edge capture.
// Holds the Avalon word-address map and the EDGE_TYPE encodings.
package nios_pio_input_irq_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RESERVED = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  // The EDGE_TYPE parameter is a plain int so that it can be set from a
  // system integration tool; these names give its legal values.
  typedef enum int {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

endpackage

// File: rtl/nios_pio_input_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// Signals:
//   address    - word address (4 registers)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - read data, combinational from address
// Modports: master (interconnect side), slave (PIO side).
interface nios_pio_input_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/nios_pio_input_irq_debounce.sv
// One input pin: 2-flop synchronizer, debounce counter and debounced flop.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   pin        - asynchronous external input
//   debounced  - filtered pin level
//   rise, fall - single-cycle strobes, high on the clock edge at which
//                debounced is about to change (combinational, so the
//                parent can capture on that same edge)
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic debounced,
  output logic rise,
  output logic fall
);

  // A one-cycle filter still needs a 1-bit counter that only ever holds 0.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_out;
  logic [CW-1:0] count;
  logic          mismatch;
  logic          qualify;

  assign mismatch = (sync_out != debounced);
  assign qualify  = mismatch && (count == CNT_LAST);
  assign rise     = qualify && sync_out;
  assign fall     = qualify && !sync_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= IDLE_LEVEL;
      sync_out  <= IDLE_LEVEL;
    end else begin
      sync_meta <= pin;
      sync_out  <= sync_meta;
    end
  end

  // The counter measures how long the synchronized pin has disagreed with
  // the debounced level; any agreement restarts the measurement.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      debounced <= IDLE_LEVEL;
    end else if (!mismatch) begin
      count <= '0;
    end else if (qualify) begin
      count     <= '0;
      debounced <= sync_out;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/nios_pio_input_irq.sv
// Avalon-MM input PIO with debounced pins, edge capture and level IRQ.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   bus        - Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port    - asynchronous external pins
//   irq        - level interrupt, high while any unmasked capture bit is set
// Registers: 0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (W1C).
module nios_pio_input_irq
  import nios_pio_input_irq_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = EDGE_FALL,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  nios_pio_input_irq_if.slave     bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  logic [WIDTH-1:0] data_db;
  logic [WIDTH-1:0] rise_stb;
  logic [WIDTH-1:0] fall_stb;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .pin       (in_port[i]),
      .debounced (data_db[i]),
      .rise      (rise_stb[i]),
      .fall      (fall_stb[i])
    );
  end

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wr_data      = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    edge_set = rise_stb | fall_stb;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_set = rise_stb;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_set = fall_stb;
    end
  end

  assign edge_clr = (wr_en && (bus.address == ADDR_EDGE_CAP)) ? wr_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && (bus.address == ADDR_IRQ_MASK)) begin
      irq_mask <= wr_data;
    end
  end

  // Set is OR-ed in after the clear so an edge arriving together with a
  // write-1-to-clear of the same bit is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:     bus.readdata[WIDTH-1:0] = data_db;
      ADDR_IRQ_MASK: bus.readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: bus.readdata[WIDTH-1:0] = edge_capture;
      default:       bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_pio_input_irq.sv
// Testbench for nios_pio_input_irq (WIDTH=4, DEBOUNCE_CYCLES=4, falling
// edge capture, idle-high pins). Reads push the expected response into a
// scoreboard queue; a monitor pops and compares when the read is presented.
// The reference model treats debouncing as "the last N synchronized
// samples all disagree with the current level".
module tb_nios_pio_input_irq;

  localparam int N = 4;

  typedef enum int { OP_IDLE, OP_RD, OP_WR } op_e;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp_data;
    logic        exp_irq;
    bit          has_const;
    logic [31:0] c_data;
    logic        c_irq;
  } rd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;
  logic [3:0] pin_val;

  int n_tests = 0;
  int n_fail  = 0;

  rd_t sb[$];

  logic [3:0] m_db;
  logic [3:0] m_cap;
  logic [3:0] m_mask;
  logic [3:0] m_samp[$];

  nios_pio_input_irq_if bus ();

  nios_pio_input_irq #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (N),
    .EDGE_TYPE       (1),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model, advanced on every rising edge.
  always @(posedge clk) begin : model
    logic [3:0] flip;
    logic [3:0] w1c;
    bit         all_diff;
    if (reset) begin
      m_db   = 4'hF;
      m_cap  = 4'h0;
      m_mask = 4'h0;
      m_samp.delete();
      for (int k = 0; k <= N; k++) m_samp.push_back(4'hF);
    end else begin
      flip = 4'h0;
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= N; k++)
          if (m_samp[k][b] == m_db[b]) all_diff = 1'b0;
        flip[b] = all_diff;
      end
      w1c = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[3:0];
      m_cap = (m_cap & ~w1c) | (flip & m_db);
      m_db  = m_db ^ flip;
      m_samp.push_front(in_port);
      void'(m_samp.pop_back());
    end
  end

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_db};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle, driven just after a falling edge.
  task automatic applyStimulus(input op_e op, input logic [1:0] a, input logic [31:0] d);
    rd_t e;
    @(negedge clk);
    in_port        = pin_val;
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = (op != OP_IDLE);
    bus.write_n    = (op != OP_WR);
    if (op == OP_RD) begin
      e.addr      = a;
      e.exp_data  = modelRead(a);
      e.exp_irq   = |(m_cap & m_mask);
      e.has_const = 1'b0;
      e.c_data    = 32'd0;
      e.c_irq     = 1'b0;
      sb.push_back(e);
    end
  endtask

  // Attach a fixed expected value to the most recently issued read.
  task automatic expectConst(input logic [31:0] d, input logic i);
    rd_t e;
    e = sb.pop_back();
    e.has_const = 1'b1;
    e.c_data    = d;
    e.c_irq     = i;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    rd_t e;
    #2;
    if (bus.chipselect && bus.write_n) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL scoreboard: read seen, got empty queue, expected an entry");
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("readdata_model@%0d", e.addr), bus.readdata, e.exp_data);
        checkOutput("irq_model", {31'd0, irq}, {31'd0, e.exp_irq});
        if (e.has_const) begin
          checkOutput($sformatf("readdata_fixed@%0d", e.addr), bus.readdata, e.c_data);
          checkOutput("irq_fixed", {31'd0, irq}, {31'd0, e.c_irq});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int hold;
    int op;
    reset          = 1'b1;
    pin_val        = 4'hF;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    applyStimulus(OP_RD, 2'd0, 0); expectConst(32'hF, 1'b0);
    applyStimulus(OP_RD, 2'd1, 0); expectConst(32'h0, 1'b0);
    applyStimulus(OP_RD, 2'd2, 0); expectConst(32'h0, 1'b0);
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h0, 1'b0);

    // Clean falling edge on bit 0: DATA changes on edge 6
    pin_val = 4'hE;
    applyStimulus(OP_RD, 2'd0, 0); expectConst(32'hF, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(OP_RD, 2'd0, 0);
      expectConst((i >= 6) ? 32'hE : 32'hF, 1'b0);
    end
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h1, 1'b0);

    // Mask over a set capture bit, then clear it
    applyStimulus(OP_WR, 2'd2, 32'h1);
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h1, 1'b1);
    applyStimulus(OP_WR, 2'd3, 32'h1);
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h0, 1'b0);

    // Three-cycle glitch on bit 2 is filtered
    pin_val = 4'hA;
    repeat (3) applyStimulus(OP_IDLE, 2'd0, 0);
    pin_val = 4'hE;
    for (int i = 0; i < 8; i++) applyStimulus(OP_RD, 2'd0, 0);
    expectConst(32'hE, 1'b0);
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h0, 1'b0);

    // Rising edge on bit 0 is not captured
    pin_val = 4'hF;
    for (int i = 0; i < 8; i++) applyStimulus(OP_RD, 2'd0, 0);
    expectConst(32'hF, 1'b0);
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h0, 1'b0);

    // Capture and W1C on the same edge: set wins
    applyStimulus(OP_WR, 2'd2, 32'h2);
    pin_val = 4'hC;
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h0, 1'b0);
    end
    applyStimulus(OP_WR, 2'd3, 32'h2);
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h3, 1'b1);

    // Reset mid-operation with pins held low
    applyStimulus(OP_WR, 2'd2, 32'hF);
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h3, 1'b1);
    applyStimulus(OP_IDLE, 2'd0, 0);
    reset = 1'b1;
    applyStimulus(OP_IDLE, 2'd0, 0);
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h0, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(OP_RD, 2'd0, 0);
      expectConst((i >= 6) ? 32'hC : 32'hF, 1'b0);
    end
    applyStimulus(OP_RD, 2'd3, 0); expectConst(32'h3, 1'b0);

    // Randomized traffic against the model
    hold = 0;
    for (int it = 0; it < 400; it++) begin
      if (hold == 0) begin
        pin_val = 4'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      op = $urandom_range(0, 3);
      if (op < 2)       applyStimulus(OP_RD, 2'($urandom), 0);
      else if (op == 2) applyStimulus(OP_WR, 2'($urandom), $urandom);
      else              applyStimulus(OP_IDLE, 2'd0, 0);
    end

    applyStimulus(OP_IDLE, 2'd0, 0);
    @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
